// File: rtl/ioctl_pkg.sv
// Shared definitions for the HPS ioctl upload readback path.
package ioctl_pkg;

  localparam int unsigned IOCTL_AW = 25;
  localparam logic [7:0]  UP_FILL  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_e;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// Answers HPS upload reads from core memory, stalling with ioctl_wait while a
// read is outstanding, and tracks byte count, checksum and timeout status.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] UP_INDEX = 8'd2,
  parameter int         TIMEOUT  = 255
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic                mem_ack,
  input  logic [7:0]          mem_data,
  output logic                core_pause,
  output logic [IOCTL_AW-1:0] up_count,
  output logic [7:0]          up_sum,
  output logic                up_error
);

  localparam logic [7:0] TO_L = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic [7:0]          ioctl_din_q, ioctl_din_d;
  logic                ioctl_wait_q, ioctl_wait_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                active_q, active_d;
  logic [IOCTL_AW-1:0] up_count_q, up_count_d;
  logic [7:0]          up_sum_q, up_sum_d;
  logic                up_error_q, up_error_d;
  logic [7:0]          timer_q, timer_d;

  logic                active_s;
  logic                in_range_s;
  logic                done_s;
  logic                err_set_s;
  logic [7:0]          ret_byte_s;

  always_comb begin
    active_s   = ioctl_upload && (ioctl_index == UP_INDEX);
    in_range_s = ((ioctl_addr >> ADDR_W) == {IOCTL_AW{1'b0}});
  end

  always_comb begin
    state_d     = state_q;
    ioctl_din_d = ioctl_din_q;
    mem_addr_d  = mem_addr_q;
    timer_d     = timer_q;
    done_s      = 1'b0;
    err_set_s   = 1'b0;
    ret_byte_s  = ioctl_din_q;

    case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        if (ioctl_rd && active_s) begin
          if (in_range_s) begin
            mem_addr_d = ioctl_addr[ADDR_W-1:0];
            timer_d    = 8'd1;
            state_d    = FETCH;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // Session ending mid-read abandons it without touching the byte or counters.
        if (!active_s) begin
          timer_d = 8'd0;
          state_d = IDLE;
        end else if (mem_ack) begin
          ret_byte_s  = mem_data;
          ioctl_din_d = mem_data;
          done_s      = 1'b1;
          timer_d     = 8'd0;
          state_d     = IDLE;
        end else if (timer_q >= TO_L) begin
          ret_byte_s  = UP_FILL;
          ioctl_din_d = UP_FILL;
          err_set_s   = 1'b1;
          done_s      = 1'b1;
          timer_d     = 8'd0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      FILL: begin
        ret_byte_s  = UP_FILL;
        ioctl_din_d = UP_FILL;
        done_s      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        timer_d = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    active_d   = active_s;
    up_count_d = up_count_q;
    up_sum_d   = up_sum_q;
    up_error_d = up_error_q;
    // A new matching session starts its statistics from zero.
    if (active_s && !active_q) begin
      up_count_d = {IOCTL_AW{1'b0}};
      up_sum_d   = 8'd0;
      up_error_d = 1'b0;
    end else begin
      up_count_d = up_count_q;
    end
    if (done_s) begin
      up_count_d = up_count_d + {{(IOCTL_AW-1){1'b0}}, 1'b1};
      up_sum_d   = sum8(up_sum_d, ret_byte_s);
    end else begin
      up_sum_d = up_sum_d;
    end
    if (err_set_s) begin
      up_error_d = 1'b1;
    end else begin
      up_error_d = up_error_d;
    end
    ioctl_wait_d = (state_d != IDLE);
    mem_rd_d     = (state_d == FETCH);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      ioctl_din_q  <= 8'h00;
      ioctl_wait_q <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_rd_q     <= 1'b0;
      active_q     <= 1'b0;
      up_count_q   <= {IOCTL_AW{1'b0}};
      up_sum_q     <= 8'd0;
      up_error_q   <= 1'b0;
      timer_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      ioctl_din_q  <= ioctl_din_d;
      ioctl_wait_q <= ioctl_wait_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      active_q     <= active_d;
      up_count_q   <= up_count_d;
      up_sum_q     <= up_sum_d;
      up_error_q   <= up_error_d;
      timer_q      <= timer_d;
    end
  end

  assign ioctl_din  = ioctl_din_q;
  assign ioctl_wait = ioctl_wait_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign core_pause = active_q;
  assign up_count   = up_count_q;
  assign up_sum     = up_sum_q;
  assign up_error   = up_error_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Self-checking bench: vector table, hand sequences and a randomized run
// against a per-request behavioural model of the upload reader.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        core_pause;
  logic [24:0] up_count;
  logic [7:0]  up_sum;
  logic        up_error;

  logic        resp_ack = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        force_ack = 1'b0;
  bit          mem_en = 1'b1;
  int          mem_lat = 0;
  int          rd_cycles = 0;
  logic [7:0]  mem [0:16383];

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  int m_sum = 0;
  bit m_err = 1'b0;

  assign mem_ack  = resp_ack | force_ack;
  assign mem_data = force_ack ? 8'h3C : resp_data;

  ioctl_upload_reader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .core_pause(core_pause), .up_count(up_count), .up_sum(up_sum),
    .up_error(up_error)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory that acks after mem_lat extra cycles of mem_rd, or never when disabled.
  always @(negedge clk_sys) begin
    if (mem_rd && !reset) begin
      rd_cycles = rd_cycles + 1;
      if (mem_en && rd_cycles > mem_lat) begin
        resp_ack  = 1'b1;
        resp_data = mem[mem_addr];
      end else begin
        resp_ack = 1'b0;
      end
    end else begin
      rd_cycles = 0;
      resp_ack  = 1'b0;
    end
  end

  typedef struct {
    logic [24:0] addr;
    int          lat;
    bit          en;
    logic [7:0]  exp_byte;
    int          exp_wait;
    bit          exp_mem;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [24:0] a, input bit en);
    if (a >= 25'd16384) return 8'hFF;
    if (!en) return 8'hFF;
    return mem[a[13:0]];
  endfunction

  function automatic int model_wait(input logic [24:0] a, input bit en, input int lat);
    if (a >= 25'd16384) return 1;
    if (!en) return 255;
    return lat + 1;
  endfunction

  task automatic model_account(input logic [24:0] a, input bit en);
    m_count = m_count + 1;
    m_sum   = (m_sum + int'(model_byte(a, en))) % 256;
    if (a < 25'd16384 && !en) m_err = 1'b1;
  endtask

  task automatic do_read(input logic [24:0] addr, output int n, output bit saw_rd,
                         output bit addr_bad);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    saw_rd = 1'b0;
    addr_bad = 1'b0;
    while (ioctl_wait && n < 400) begin
      if (mem_rd) begin
        saw_rd = 1'b1;
        if (mem_addr !== addr[13:0]) addr_bad = 1'b1;
      end
      n++;
      tick();
    end
  endtask

  task automatic new_session(input logic [7:0] idx);
    ioctl_upload = 1'b0;
    tick();
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    tick();
    m_count = 0;
    m_sum   = 0;
    m_err   = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [24:0] a, input bit en, input int lat);
    int  n;
    bit  saw, bad;
    mem_en  = en;
    mem_lat = lat;
    do_read(a, n, saw, bad);
    model_account(a, en);
    check({tag, "_din"},   ioctl_din, model_byte(a, en));
    check({tag, "_wait"},  n, model_wait(a, en, lat));
    check({tag, "_memrd"}, saw, (a < 25'd16384) ? 1 : 0);
    check({tag, "_addr"},  bad, 0);
  endtask

  initial begin
    int  n;
    bit  saw, bad;
    int  bad_bytes;
    logic [7:0]  din_save;
    logic [24:0] cnt_save;
    logic [24:0] ra;

    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h55;
    mem[16'h3FFF] = 8'hC3;
    mem[16'h0001] = 8'h9A;

    vecs[0] = '{addr: 25'h0000010, lat: 2, en: 1'b1, exp_byte: 8'h55, exp_wait: 3, exp_mem: 1'b1};
    vecs[1] = '{addr: 25'h0004000, lat: 0, en: 1'b1, exp_byte: 8'hFF, exp_wait: 1, exp_mem: 1'b0};
    vecs[2] = '{addr: 25'h1FFFFFF, lat: 0, en: 1'b1, exp_byte: 8'hFF, exp_wait: 1, exp_mem: 1'b0};
    vecs[3] = '{addr: 25'h0003FFF, lat: 0, en: 1'b1, exp_byte: 8'hC3, exp_wait: 1, exp_mem: 1'b1};
    vecs[4] = '{addr: 25'h0000001, lat: 5, en: 1'b1, exp_byte: 8'h9A, exp_wait: 6, exp_mem: 1'b1};

    repeat (3) tick();
    check("rst_din",   ioctl_din, 8'h00);
    check("rst_wait",  ioctl_wait, 1'b0);
    check("rst_memrd", mem_rd, 1'b0);
    check("rst_maddr", mem_addr, 14'd0);
    check("rst_pause", core_pause, 1'b0);
    check("rst_count", up_count, 25'd0);
    check("rst_sum",   up_sum, 8'd0);
    check("rst_err",   up_error, 1'b0);
    reset = 1'b0;
    tick();

    new_session(8'd2);
    check("pause_on", core_pause, 1'b1);

    for (int v = 0; v < 5; v++) begin
      mem_en  = vecs[v].en;
      mem_lat = vecs[v].lat;
      do_read(vecs[v].addr, n, saw, bad);
      m_count = m_count + 1;
      m_sum   = (m_sum + int'(vecs[v].exp_byte)) % 256;
      check($sformatf("vec%0d_din", v),   ioctl_din, vecs[v].exp_byte);
      check($sformatf("vec%0d_wait", v),  n, vecs[v].exp_wait);
      check($sformatf("vec%0d_memrd", v), saw, vecs[v].exp_mem);
      check($sformatf("vec%0d_addr", v),  bad, 1'b0);
      check($sformatf("vec%0d_count", v), up_count, m_count);
      check($sformatf("vec%0d_sum", v),   up_sum, m_sum);
    end
    check("vec_err", up_error, 1'b0);

    // Timeout: memory never acks; error sticks through a later good read.
    run_one("tmo", 25'h0000020, 1'b0, 0);
    check("tmo_err", up_error, 1'b1);
    check("tmo_count", up_count, m_count);
    run_one("post_tmo", 25'h0000021, 1'b1, 1);
    check("post_tmo_err", up_error, 1'b1);

    new_session(8'd2);
    check("clr_count", up_count, 25'd0);
    check("clr_sum",   up_sum, 8'd0);
    check("clr_err",   up_error, 1'b0);

    // 256 back-to-back zero-wait reads of a memory holding addr[7:0].
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem_en = 1'b1;
    mem_lat = 0;
    bad_bytes = 0;
    for (int i = 0; i < 256; i++) begin
      do_read(25'(i), n, saw, bad);
      if (ioctl_din !== 8'(i) || n != 1 || !saw || bad) bad_bytes++;
    end
    check("b2b_bytes", bad_bytes, 0);
    check("b2b_count", up_count, 25'd256);
    check("b2b_sum",   up_sum, 8'h80);

    new_session(8'd2);
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) ra = 25'h4000 + 25'($urandom_range(0, 100000));
      else ra = 25'($urandom_range(0, 16383));
      run_one($sformatf("rnd%0d", k), ra, ($urandom_range(0, 19) != 0), int'($urandom_range(0, 4)));
    end
    check("rnd_count", up_count, m_count);
    check("rnd_sum",   up_sum, m_sum);
    check("rnd_err",   up_error, m_err);

    // Non-matching index: strobes must be ignored entirely.
    cnt_save = up_count;
    din_save = ioctl_din;
    new_session(8'd0);
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ioctl_addr = 25'(k * 3);
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      if (mem_rd || ioctl_wait) saw = 1'b1;
      tick();
      if (mem_rd || ioctl_wait) saw = 1'b1;
    end
    check("idx0_busy",  saw, 1'b0);
    check("idx0_pause", core_pause, 1'b0);
    check("idx0_count", up_count, cnt_save);
    check("idx0_din",   ioctl_din, din_save);

    // Abort by dropping the session mid-fetch.
    new_session(8'd2);
    run_one("pre_abort", 25'h0000005, 1'b1, 0);
    din_save = ioctl_din;
    mem_en = 1'b0;
    ioctl_addr = 25'h0000006;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("abort_memrd_hi", mem_rd, 1'b1);
    check("abort_wait_hi",  ioctl_wait, 1'b1);
    tick();
    tick();
    ioctl_upload = 1'b0;
    tick();
    check("abort_memrd", mem_rd, 1'b0);
    check("abort_wait",  ioctl_wait, 1'b0);
    check("abort_count", up_count, 25'd1);
    check("abort_din",   ioctl_din, din_save);

    // Reset mid-fetch, then a stray ack must be ignored.
    ioctl_upload = 1'b1;
    tick();
    ioctl_addr = 25'h0000007;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check("rfetch_memrd_hi", mem_rd, 1'b1);
    reset = 1'b1;
    tick();
    check("rfetch_memrd", mem_rd, 1'b0);
    check("rfetch_wait",  ioctl_wait, 1'b0);
    check("rfetch_din",   ioctl_din, 8'h00);
    check("rfetch_count", up_count, 25'd0);
    check("rfetch_maddr", mem_addr, 14'd0);
    check("rfetch_pause", core_pause, 1'b0);
    ioctl_upload = 1'b0;
    reset = 1'b0;
    force_ack = 1'b1;
    mem_en = 1'b1;
    repeat (3) tick();
    force_ack = 1'b0;
    check("late_ack_din",   ioctl_din, 8'h00);
    check("late_ack_memrd", mem_rd, 1'b0);
    check("late_ack_wait",  ioctl_wait, 1'b0);
    check("late_ack_count", up_count, 25'd0);
    check("late_ack_sum",   up_sum, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
